// File: rtl/button_arbiter.sv
// Round-robin arbiter for debounced button pulses: latches requests in a
// pending vector and presents one command at a time, with idle gap cycles after each one.
module button_arbiter #(
    parameter int N   = 4,
    parameter int GAP = 4,
    localparam int W  = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_pulse,
    input  logic         cmd_ready,
    input  logic         clr_overflow,
    output logic         cmd_valid,
    output logic [W-1:0] cmd_id,
    output logic [N-1:0] pending,
    output logic         overflow
);

    typedef enum logic [1:0] {IDLE, PRESENT, HOLD} state_t;

    localparam logic [7:0]   GAP_LOAD  = (GAP > 0) ? 8'(GAP - 1) : 8'd0;
    localparam logic [W-1:0] LAST_INIT = W'(N - 1);
    localparam logic [W:0]   N_WIDE    = (W + 1)'(N);

    state_t         state, state_next;
    logic [7:0]     gap_cnt, gap_next;
    logic [W-1:0]   last_grant, last_next;
    logic [W-1:0]   grant_id, id_next;
    logic           grant_found, grant_now;
    logic           valid_next, overflow_next;
    logic [N-1:0]   grant_mask, pending_next;

    // (base + off) mod N without a divider; the sum never reaches 2N
    function automatic logic [W-1:0] rr_index(input logic [W-1:0] base, input int off);
        logic [W:0] sum;
        sum = {1'b0, base} + (W + 1)'(off);
        if (sum >= N_WIDE)
            sum = sum - N_WIDE;
        return sum[W-1:0];
    endfunction

    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        for (int off = 1; off <= N; off++) begin
            if (!grant_found && pending[rr_index(last_grant, off)]) begin
                grant_found = 1'b1;
                grant_id    = rr_index(last_grant, off);
            end
        end
    end

    always_comb begin
        state_next = state;
        gap_next   = gap_cnt;
        valid_next = cmd_valid;
        id_next    = cmd_id;
        last_next  = last_grant;
        grant_now  = 1'b0;
        unique case (state)
            IDLE: begin
                if (grant_found) begin
                    grant_now  = 1'b1;
                    valid_next = 1'b1;
                    id_next    = grant_id;
                    last_next  = grant_id;
                    state_next = PRESENT;
                end
            end
            PRESENT: begin
                if (cmd_ready) begin
                    valid_next = 1'b0;
                    if (GAP == 0) begin
                        state_next = IDLE;
                    end else begin
                        state_next = HOLD;
                        gap_next   = GAP_LOAD;
                    end
                end
            end
            HOLD: begin
                if (gap_cnt == 8'd0)
                    state_next = IDLE;
                else
                    gap_next = gap_cnt - 8'd1;
            end
            default: state_next = IDLE;
        endcase

        // A pulse on the requester being granted re-arms it rather than counting as lost
        grant_mask    = grant_now ? (N'(1) << grant_id) : '0;
        pending_next  = (pending & ~grant_mask) | req_pulse;
        overflow_next = (|(req_pulse & pending & ~grant_mask)) ? 1'b1
                      : (clr_overflow ? 1'b0 : overflow);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            gap_cnt    <= 8'd0;
            last_grant <= LAST_INIT;
            cmd_valid  <= 1'b0;
            cmd_id     <= '0;
            pending    <= '0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_next;
            gap_cnt    <= gap_next;
            last_grant <= last_next;
            cmd_valid  <= valid_next;
            cmd_id     <= id_next;
            pending    <= pending_next;
            overflow   <= overflow_next;
        end
    end

endmodule

// File: tb/tb_button_arbiter.sv
// Directed bench for button_arbiter: a GAP=4 instance checked throughout and a
// GAP=0 instance sharing the same inputs for the back-to-back regrant case.
module tb_button_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req_pulse;
    logic       cmd_ready;
    logic       clr_overflow;

    logic       cmd_valid, overflow;
    logic [1:0] cmd_id;
    logic [3:0] pending;

    logic       cmd_valid_g0, overflow_g0;
    logic [1:0] cmd_id_g0;
    logic [3:0] pending_g0;

    int checks   = 0;
    int failures = 0;
    int low;
    int grants;

    button_arbiter #(.N(4), .GAP(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_pulse(req_pulse), .cmd_ready(cmd_ready),
        .clr_overflow(clr_overflow), .cmd_valid(cmd_valid), .cmd_id(cmd_id),
        .pending(pending), .overflow(overflow)
    );

    button_arbiter #(.N(4), .GAP(0)) u_dut_g0 (
        .clk(clk), .rst_n(rst_n), .req_pulse(req_pulse), .cmd_ready(cmd_ready),
        .clr_overflow(clr_overflow), .cmd_valid(cmd_valid_g0), .cmd_id(cmd_id_g0),
        .pending(pending_g0), .overflow(overflow_g0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of inputs, take the edge, then drop the single-cycle pulses
    task automatic applyStimulus(input logic [3:0] req, input logic ready, input logic clr);
        req_pulse    = req;
        cmd_ready    = ready;
        clr_overflow = clr;
        step();
        req_pulse    = 4'b0000;
        clr_overflow = 1'b0;
    endtask

    task automatic apply_reset();
        req_pulse    = 4'b0000;
        cmd_ready    = 1'b0;
        clr_overflow = 1'b0;
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        step();
    endtask

    // Counts low cycles of cmd_valid on the GAP=4 instance until it rises again
    task automatic measure_gap(input int start, output int count);
        count = start;
        for (int i = 0; i < 40; i++) begin
            if (cmd_valid) break;
            count++;
            step();
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        req_pulse    = 4'b0000;
        cmd_ready    = 1'b0;
        clr_overflow = 1'b0;
        #2;
        checkOutput("reset_valid",    cmd_valid, 0);
        checkOutput("reset_id",       cmd_id,    0);
        checkOutput("reset_pending",  pending,   0);
        checkOutput("reset_overflow", overflow,  0);
        #5 rst_n = 1'b1;
        step();

        $display("[TB] single request");
        applyStimulus(4'b0100, 1'b1, 1'b0);
        checkOutput("single_pending_set", {cmd_valid, pending}, {1'b0, 4'b0100});
        applyStimulus(4'b0000, 1'b1, 1'b0);
        checkOutput("single_present", {cmd_valid, cmd_id, pending}, {1'b1, 2'd2, 4'b0000});
        applyStimulus(4'b0000, 1'b1, 1'b0);
        checkOutput("single_handshake", {cmd_valid, pending, overflow}, {1'b0, 4'b0000, 1'b0});

        $display("[TB] round robin");
        apply_reset();
        applyStimulus(4'b1011, 1'b1, 1'b0);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        checkOutput("rr_first", {cmd_valid, cmd_id, pending}, {1'b1, 2'd0, 4'b1010});
        applyStimulus(4'b0000, 1'b1, 1'b0);
        measure_gap(0, low);
        checkOutput("rr_gap1", low, 5);
        checkOutput("rr_second", {cmd_valid, cmd_id}, {1'b1, 2'd1});
        applyStimulus(4'b0000, 1'b1, 1'b0);
        measure_gap(0, low);
        checkOutput("rr_gap2", low, 5);
        checkOutput("rr_third", {cmd_valid, cmd_id}, {1'b1, 2'd3});
        applyStimulus(4'b0000, 1'b1, 1'b0);
        checkOutput("rr_drained", {cmd_valid, pending}, {1'b0, 4'b0000});

        $display("[TB] backpressure");
        apply_reset();
        applyStimulus(4'b0010, 1'b0, 1'b0);
        applyStimulus(4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus((i == 2) ? 4'b1000 : 4'b0000, 1'b0, 1'b0);
            checkOutput("bp_hold", {cmd_valid, cmd_id}, {1'b1, 2'd1});
        end
        checkOutput("bp_pending", pending, 4'b1000);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        checkOutput("bp_handshake", cmd_valid, 0);
        measure_gap(0, low);
        checkOutput("bp_gap", low, 5);
        checkOutput("bp_next", {cmd_valid, cmd_id}, {1'b1, 2'd3});

        $display("[TB] overflow");
        apply_reset();
        applyStimulus(4'b0001, 1'b1, 1'b0);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        checkOutput("ovf_grant0", {cmd_valid, cmd_id}, {1'b1, 2'd0});
        applyStimulus(4'b0000, 1'b1, 1'b0);
        applyStimulus(4'b0001, 1'b1, 1'b0);
        checkOutput("ovf_first_pulse", {pending, overflow}, {4'b0001, 1'b0});
        applyStimulus(4'b0001, 1'b1, 1'b0);
        checkOutput("ovf_second_pulse", {pending, overflow}, {4'b0001, 1'b1});
        measure_gap(0, low);
        checkOutput("ovf_hold_gap", low, 3);
        checkOutput("ovf_regrant", {cmd_valid, cmd_id}, {1'b1, 2'd0});
        applyStimulus(4'b0000, 1'b1, 1'b0);
        grants = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (cmd_valid) grants++;
        end
        checkOutput("ovf_single_grant", grants, 0);
        checkOutput("ovf_sticky", overflow, 1);
        applyStimulus(4'b0100, 1'b0, 1'b0);
        applyStimulus(4'b0000, 1'b0, 1'b0);
        applyStimulus(4'b0001, 1'b0, 1'b0);
        applyStimulus(4'b0001, 1'b0, 1'b1);
        checkOutput("ovf_set_wins", {overflow, cmd_id}, {1'b1, 2'd2});
        applyStimulus(4'b0000, 1'b0, 1'b1);
        checkOutput("ovf_clear", overflow, 0);

        $display("[TB] same-edge regrant");
        apply_reset();
        applyStimulus(4'b0010, 1'b1, 1'b0);
        applyStimulus(4'b0010, 1'b1, 1'b0);
        checkOutput("regrant_g4", {cmd_valid, cmd_id, pending, overflow}, {1'b1, 2'd1, 4'b0010, 1'b0});
        checkOutput("regrant_g0", {cmd_valid_g0, cmd_id_g0, pending_g0, overflow_g0}, {1'b1, 2'd1, 4'b0010, 1'b0});
        applyStimulus(4'b0000, 1'b1, 1'b0);
        checkOutput("regrant_g0_low", cmd_valid_g0, 0);
        step();
        checkOutput("regrant_g0_again", {cmd_valid_g0, cmd_id_g0}, {1'b1, 2'd1});
        measure_gap(1, low);
        checkOutput("regrant_g4_gap", low, 5);
        checkOutput("regrant_g4_again", {cmd_valid, cmd_id, overflow}, {1'b1, 2'd1, 1'b0});

        $display("[TB] async reset");
        apply_reset();
        applyStimulus(4'b0010, 1'b0, 1'b0);
        applyStimulus(4'b0000, 1'b0, 1'b0);
        applyStimulus(4'b1010, 1'b0, 1'b0);
        checkOutput("ares_before", {cmd_valid, cmd_id, pending}, {1'b1, 2'd1, 4'b1010});
        #2 rst_n = 1'b0;
        #1;
        checkOutput("ares_immediate", {cmd_valid, cmd_id, pending, overflow}, {1'b0, 2'd0, 4'b0000, 1'b0});
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step();
        checkOutput("ares_nothing_back", {cmd_valid, pending}, {1'b0, 4'b0000});
        applyStimulus(4'b1111, 1'b1, 1'b0);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        checkOutput("ares_first_id0", {cmd_valid, cmd_id, pending}, {1'b1, 2'd0, 4'b1110});

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/button_arbiter.md
BUTTON_ARBITER -- requirements
Module: button_arbiter

Interface
REQ-001 Parameter N, default 4: number of requesters (debounced button pulse sources), range 2..16.
REQ-002 Parameter GAP, default 4: idle cycles inserted after each accepted command, range 0..255.
REQ-003 Derived width W = clog2(N), used for cmd_id.
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req_pulse  input  N  single-cycle request pulses, one bit per requester, synchronous to clk.
REQ-007 cmd_ready  input  1  downstream consumer accepts the current command.
REQ-008 clr_overflow  input  1  synchronous clear of the overflow flag.
REQ-009 cmd_valid  output  1  command available on cmd_id.
REQ-010 cmd_id  output  W  index of the granted requester.
REQ-011 pending  output  N  registered pending-request vector.
REQ-012 overflow  output  1  sticky flag: a request was lost.

Function
REQ-013 The block SHALL use three states: IDLE, PRESENT and HOLD.
REQ-014 pending[i] SHALL be set at the edge where req_pulse[i]=1.
REQ-015 pending[i] SHALL be cleared at the edge where requester i is granted.
REQ-016 If req_pulse[i]=1 at the same edge requester i is granted, pending[i] SHALL stay 1 and overflow SHALL NOT be set.
REQ-017 If req_pulse[i]=1 while pending[i]=1 and i is not granted at that edge, overflow SHALL be set; pending[i] stays 1.
REQ-018 In IDLE, if pending is nonzero at an edge, the block SHALL grant one requester, load cmd_id, set cmd_valid=1 and enter PRESENT.
REQ-019 In IDLE, if pending is zero, the block SHALL stay in IDLE with cmd_valid=0.
REQ-020 Grant selection SHALL be round-robin: first set pending bit searching from last_grant+1 upward, modulo N.
REQ-021 last_grant SHALL be updated to the granted index on every grant.
REQ-022 Latency: req_pulse[i] at edge k with the block in IDLE and no other pending SHALL give cmd_valid=1 and cmd_id=i after edge k+1.
REQ-023 In PRESENT, cmd_valid and cmd_id SHALL hold stable until an edge with cmd_ready=1.
REQ-024 At the edge where cmd_valid=1 and cmd_ready=1, cmd_valid SHALL go 0.
REQ-025 At that handshake edge, state SHALL become IDLE if GAP=0; otherwise HOLD, with the gap counter loaded to GAP-1.
REQ-026 In HOLD, the counter SHALL decrement each edge and the block SHALL go to IDLE at the edge where the counter equals 0.
REQ-027 Net effect: cmd_valid SHALL stay low for exactly GAP+1 cycles between a handshake and the next assertion when requests are pending.
REQ-028 cmd_ready SHALL be ignored when cmd_valid=0.
REQ-029 Requests arriving in PRESENT or HOLD SHALL accumulate in pending and not be lost unless REQ-017 applies.
REQ-030 overflow SHALL be cleared at an edge with clr_overflow=1.
REQ-031 If clr_overflow=1 and a new overflow event occur at the same edge, overflow SHALL be 1 (set wins).
REQ-032 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-033 rst_n=0 SHALL immediately force cmd_valid=0, cmd_id=0, pending=0, overflow=0, state IDLE, gap counter 0 and last_grant=N-1, without waiting for a clock edge.
REQ-034 Reset asserted mid-command SHALL discard the presented command and all pending requests; none SHALL reappear after reset release.
REQ-035 After rst_n rises, the first grant with all requesters pending SHALL be index 0.

Verification
REQ-036 Single request (N=4, GAP=4): pulse on req 2 at edge k, cmd_ready=1 -> cmd_valid=1, cmd_id=2 after edge k+1; handshake at edge k+2; pending=0; overflow=0.
REQ-037 Round-robin: pulse reqs 0,1,3 in the same cycle, cmd_ready=1 -> cmd_id sequence 0,1,3; cmd_valid low exactly 5 cycles between commands.
REQ-038 Backpressure: cmd_ready=0 for 10 cycles while presenting id 1; a new pulse arrives on req 3 -> cmd_id stays 1 throughout; id 3 is granted after GAP+1 cycles once ready rises.
REQ-039 Overflow: two pulses on req 0 while pending[0]=1 and the block is in HOLD -> overflow=1, only one grant of id 0. Then clr_overflow together with a new overflow event -> overflow stays 1.
REQ-040 Same-edge regrant: pulse req 1 on the edge it is granted -> pending[1]=1 afterwards, overflow=0, id 1 presented again after GAP+1 cycles. With GAP=0, spacing is 1 cycle.
REQ-041 Async reset: assert rst_n=0 between edges while cmd_valid=1 and pending=4'b1010 -> cmd_valid=0 and pending=0 at once. After release, pulse all reqs -> first cmd_id=0.
